// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ALU control sequencer: ALUOp classes, Funct/opcode
// codes, control-word values and the sequencer state type.
package alu_ctrl_pkg;

  localparam logic [1:0] ALUOP_MEM = 2'b00;
  localparam logic [1:0] ALUOP_BR  = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;
  localparam logic [1:0] ALUOP_I   = 2'b11;

  localparam logic [5:0] FUNCT_ADD = 6'd32;
  localparam logic [5:0] FUNCT_SUB = 6'd34;
  localparam logic [5:0] FUNCT_AND = 6'd36;
  localparam logic [5:0] FUNCT_OR  = 6'd37;
  localparam logic [5:0] FUNCT_SLT = 6'd42;
  localparam logic [5:0] FUNCT_MUL = 6'd24;
  localparam logic [5:0] FUNCT_DIV = 6'd26;

  localparam logic [5:0] OP_ADDI = 6'd4;
  localparam logic [5:0] OP_ORI  = 6'd5;
  localparam logic [5:0] OP_ANDI = 6'd6;
  localparam logic [5:0] OP_SLTI = 6'd7;

  localparam logic [3:0] CTRL_AND = 4'd0;
  localparam logic [3:0] CTRL_OR  = 4'd1;
  localparam logic [3:0] CTRL_ADD = 4'd2;
  localparam logic [3:0] CTRL_MUL = 4'd3;
  localparam logic [3:0] CTRL_DIV = 4'd4;
  localparam logic [3:0] CTRL_SUB = 4'd6;
  localparam logic [3:0] CTRL_SLT = 4'd7;
  // Sign-extended to the configured width so NOP stays all ones.
  localparam logic signed [3:0] CTRL_NOP = 4'hF;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_MULTI = 1'b1
  } state_e;

endpackage

// File: rtl/alu_ctrl_seq_if.sv
// Request/response bundle between the control unit (master) and the ALU
// control sequencer (slave).
interface alu_ctrl_seq_if #(
  parameter int CTRL_W  = 4,
  parameter int FUNCT_W = 6,
  parameter int OP_W    = 6
);
  logic               InValid;
  logic               InReady;
  logic [1:0]         ALUOp;
  logic [FUNCT_W-1:0] Funct;
  logic [OP_W-1:0]    Opcode;
  logic               Flush;
  logic [CTRL_W-1:0]  ALUCtrl;
  logic               OutValid;
  logic               Busy;
  logic               IllegalOp;

  modport master (
    output InValid, ALUOp, Funct, Opcode, Flush,
    input  InReady, ALUCtrl, OutValid, Busy, IllegalOp
  );

  modport slave (
    input  InValid, ALUOp, Funct, Opcode, Flush,
    output InReady, ALUCtrl, OutValid, Busy, IllegalOp
  );
endinterface

// File: rtl/alu_ctrl_decode.sv
// Combinational decode of ALUOp/Funct/Opcode into the ALU control word plus
// multi-cycle and illegal-code classification.
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
#(
  parameter int CTRL_W  = 4,
  parameter int FUNCT_W = 6,
  parameter int OP_W    = 6
) (
  input  logic [1:0]         aluop_i,
  input  logic [FUNCT_W-1:0] funct_i,
  input  logic [OP_W-1:0]    opcode_i,
  output logic [CTRL_W-1:0]  ctrl_o,
  output logic               is_multi_o,
  output logic               is_div_o,
  output logic               illegal_o
);

  localparam logic [CTRL_W-1:0] NOP_W = CTRL_W'(CTRL_NOP);

  // Decode table; anything not listed falls out as NOP with illegal set.
  always_comb begin
    ctrl_o     = NOP_W;
    is_multi_o = 1'b0;
    is_div_o   = 1'b0;
    illegal_o  = 1'b0;
    case (aluop_i)
      ALUOP_MEM: ctrl_o = CTRL_W'(CTRL_ADD);
      ALUOP_BR:  ctrl_o = CTRL_W'(CTRL_SUB);
      ALUOP_R: begin
        case (funct_i)
          FUNCT_W'(FUNCT_ADD): ctrl_o = CTRL_W'(CTRL_ADD);
          FUNCT_W'(FUNCT_SUB): ctrl_o = CTRL_W'(CTRL_SUB);
          FUNCT_W'(FUNCT_AND): ctrl_o = CTRL_W'(CTRL_AND);
          FUNCT_W'(FUNCT_OR):  ctrl_o = CTRL_W'(CTRL_OR);
          FUNCT_W'(FUNCT_SLT): ctrl_o = CTRL_W'(CTRL_SLT);
          FUNCT_W'(FUNCT_MUL): begin
            ctrl_o     = CTRL_W'(CTRL_MUL);
            is_multi_o = 1'b1;
          end
          FUNCT_W'(FUNCT_DIV): begin
            ctrl_o     = CTRL_W'(CTRL_DIV);
            is_multi_o = 1'b1;
            is_div_o   = 1'b1;
          end
          default: illegal_o = 1'b1;
        endcase
      end
      ALUOP_I: begin
        case (opcode_i)
          OP_W'(OP_ADDI): ctrl_o = CTRL_W'(CTRL_ADD);
          OP_W'(OP_ANDI): ctrl_o = CTRL_W'(CTRL_AND);
          OP_W'(OP_ORI):  ctrl_o = CTRL_W'(CTRL_OR);
          OP_W'(OP_SLTI): ctrl_o = CTRL_W'(CTRL_SLT);
          default:        illegal_o = 1'b1;
        endcase
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_seq.sv
// Registered ALU control unit: decodes on accept and sequences MUL/DIV through
// a busy down-counter with a valid/ready handshake.
module alu_ctrl_seq
  import alu_ctrl_pkg::*;
#(
  parameter int CTRL_W     = 4,
  parameter int FUNCT_W    = 6,
  parameter int OP_W       = 6,
  parameter int MUL_CYCLES = 8,
  parameter int DIV_CYCLES = 16
) (
  input  logic          Clock,
  input  logic          Reset,
  alu_ctrl_seq_if.slave bus
);

  localparam int                CNT_W = $clog2(DIV_CYCLES);
  localparam logic [CTRL_W-1:0] NOP_W = CTRL_W'(CTRL_NOP);
  localparam logic [CNT_W-1:0]  MUL_LOAD = CNT_W'(MUL_CYCLES - 2);
  localparam logic [CNT_W-1:0]  DIV_LOAD = CNT_W'(DIV_CYCLES - 2);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              out_valid_q, out_valid_d;
  logic              illegal_q, illegal_d;

  logic [CTRL_W-1:0] dec_ctrl_s;
  logic              dec_multi_s;
  logic              dec_div_s;
  logic              dec_illegal_s;
  logic              in_ready_s;
  logic              accept_s;

  alu_ctrl_decode #(
    .CTRL_W (CTRL_W),
    .FUNCT_W(FUNCT_W),
    .OP_W   (OP_W)
  ) u_decode (
    .aluop_i   (bus.ALUOp),
    .funct_i   (bus.Funct),
    .opcode_i  (bus.Opcode),
    .ctrl_o    (dec_ctrl_s),
    .is_multi_o(dec_multi_s),
    .is_div_o  (dec_div_s),
    .illegal_o (dec_illegal_s)
  );

  assign in_ready_s = (state_q == ST_IDLE) & ~bus.Flush;
  assign accept_s   = bus.InValid & in_ready_s;

  // Next-state, counter and output-register update; Flush overrides all.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ctrl_d      = ctrl_q;
    out_valid_d = 1'b0;
    illegal_d   = 1'b0;
    if (bus.Flush) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      ctrl_d  = NOP_W;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept_s) begin
            ctrl_d = dec_ctrl_s;
            if (dec_multi_s) begin
              state_d = ST_MULTI;
              cnt_d   = dec_div_s ? DIV_LOAD : MUL_LOAD;
            end else begin
              out_valid_d = 1'b1;
              illegal_d   = dec_illegal_s;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_MULTI: begin
          if (cnt_q == '0) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          ctrl_d  = NOP_W;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      ctrl_q      <= NOP_W;
      out_valid_q <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ctrl_q      <= ctrl_d;
      out_valid_q <= out_valid_d;
      illegal_q   <= illegal_d;
    end
  end

  assign bus.InReady   = in_ready_s;
  assign bus.ALUCtrl   = ctrl_q;
  assign bus.OutValid  = out_valid_q;
  assign bus.Busy      = (state_q == ST_MULTI);
  assign bus.IllegalOp = illegal_q;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Self-checking bench for alu_ctrl_seq: decode vector table with a result
// scoreboard, plus directed MUL, flushed DIV and mid-stream reset sequences.
module tb_alu_ctrl_seq;

  localparam int MUL_N = 8;
  localparam int DIV_N = 16;
  localparam int NV    = 19;

  typedef struct {
    logic [1:0] aluop;
    logic [5:0] funct;
    logic [5:0] opcode;
    logic [3:0] exp_ctrl;
    logic       exp_ill;
  } vec_t;

  typedef struct {
    logic [3:0] ctrl;
    logic       ill;
  } exp_t;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  int   n_vec = 0;
  int   n_mis = 0;
  int   ov_cnt = 0;
  exp_t exp_q[$];
  vec_t tbl[NV];

  alu_ctrl_seq_if #(.CTRL_W(4), .FUNCT_W(6), .OP_W(6)) bus ();

  alu_ctrl_seq #(
    .CTRL_W(4), .FUNCT_W(6), .OP_W(6), .MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .bus  (bus)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic push(input logic [3:0] c, input logic il);
    exp_t e;
    e.ctrl = c;
    e.ill  = il;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic v, input logic [1:0] a, input logic [5:0] f, input logic [5:0] o);
    bus.InValid = v;
    bus.ALUOp   = a;
    bus.Funct   = f;
    bus.Opcode  = o;
  endtask

  // Scoreboard: every OutValid pulse consumes one expected result.
  always @(negedge Clock) begin
    if (!Reset) begin
      if (bus.OutValid) begin
        ov_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_outvalid", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("sb_ctrl", 32'(bus.ALUCtrl), 32'(e.ctrl));
          chk("sb_illegal", 32'(bus.IllegalOp), 32'(e.ill));
        end
      end
      if (bus.Busy && bus.OutValid) chk("busy_and_outvalid", 32'd1, 32'd0);
      if (bus.IllegalOp && !bus.OutValid) chk("illegal_without_outvalid", 32'd1, 32'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{2'b10, 6'd32, 6'd0, 4'd2, 1'b0};
    tbl[1]  = '{2'b10, 6'd34, 6'd0, 4'd6, 1'b0};
    tbl[2]  = '{2'b10, 6'd36, 6'd0, 4'd0, 1'b0};
    tbl[3]  = '{2'b10, 6'd37, 6'd0, 4'd1, 1'b0};
    tbl[4]  = '{2'b10, 6'd42, 6'd0, 4'd7, 1'b0};
    tbl[5]  = '{2'b11, 6'd0,  6'd4, 4'd2, 1'b0};
    tbl[6]  = '{2'b11, 6'd0,  6'd6, 4'd0, 1'b0};
    tbl[7]  = '{2'b11, 6'd0,  6'd5, 4'd1, 1'b0};
    tbl[8]  = '{2'b11, 6'd0,  6'd7, 4'd7, 1'b0};
    tbl[9]  = '{2'b11, 6'd0,  6'd9, 4'hF, 1'b1};
    tbl[10] = '{2'b10, 6'd0,  6'd0, 4'hF, 1'b1};
    for (int i = 11; i < NV; i++) begin
      tbl[i].aluop    = (i < 15) ? 2'b00 : 2'b01;
      tbl[i].funct    = 6'($urandom_range(63, 0));
      tbl[i].opcode   = 6'($urandom_range(63, 0));
      tbl[i].exp_ctrl = (i < 15) ? 4'd2 : 4'd6;
      tbl[i].exp_ill  = 1'b0;
    end

    bus.Flush = 1'b0;
    drive(1'b0, 2'b00, 6'd0, 6'd0);

    // Reset state.
    @(negedge Clock);
    chk("rst_ctrl", 32'(bus.ALUCtrl), 32'hF);
    chk("rst_outvalid", 32'(bus.OutValid), 32'd0);
    chk("rst_busy", 32'(bus.Busy), 32'd0);
    chk("rst_illegal", 32'(bus.IllegalOp), 32'd0);
    @(posedge Clock); #1 Reset = 1'b0;
    @(negedge Clock);
    chk("rst_inready", 32'(bus.InReady), 32'd1);

    // Back-to-back decode table.
    @(posedge Clock); #1;
    ov_cnt = 0;
    for (int i = 0; i < NV; i++) begin
      drive(1'b1, tbl[i].aluop, tbl[i].funct, tbl[i].opcode);
      push(tbl[i].exp_ctrl, tbl[i].exp_ill);
      @(posedge Clock); #1;
    end
    drive(1'b0, 2'b00, 6'd0, 6'd0);
    @(posedge Clock); #1;
    chk("b2b_outvalid_cycles", 32'(ov_cnt), 32'(NV));
    @(negedge Clock);
    chk("b2b_outvalid_drop", 32'(bus.OutValid), 32'd0);

    // MUL with a follow-up request held during Busy.
    @(posedge Clock); #1;
    drive(1'b1, 2'b10, 6'd24, 6'd0);
    push(4'd3, 1'b0);
    @(posedge Clock); #1;
    drive(1'b1, 2'b10, 6'd32, 6'd0);
    push(4'd2, 1'b0);
    for (int c = 0; c < MUL_N - 1; c++) begin
      @(negedge Clock);
      chk("mul_busy", 32'(bus.Busy), 32'd1);
      chk("mul_inready", 32'(bus.InReady), 32'd0);
      chk("mul_ctrl", 32'(bus.ALUCtrl), 32'd3);
    end
    @(negedge Clock);
    chk("mul_done_busy", 32'(bus.Busy), 32'd0);
    chk("mul_done_outvalid", 32'(bus.OutValid), 32'd1);
    chk("mul_done_inready", 32'(bus.InReady), 32'd1);
    @(posedge Clock); #1;
    drive(1'b0, 2'b00, 6'd0, 6'd0);
    @(negedge Clock);
    chk("mul_next_outvalid", 32'(bus.OutValid), 32'd1);
    chk("mul_next_ctrl", 32'(bus.ALUCtrl), 32'd2);

    // DIV flushed in its 5th Busy cycle with a concurrent request.
    @(posedge Clock); #1;
    drive(1'b1, 2'b10, 6'd26, 6'd0);
    @(posedge Clock); #1;
    drive(1'b0, 2'b00, 6'd0, 6'd0);
    repeat (4) @(posedge Clock);
    #1;
    bus.Flush = 1'b1;
    drive(1'b1, 2'b10, 6'd32, 6'd0);
    @(negedge Clock);
    chk("flush_busy", 32'(bus.Busy), 32'd1);
    chk("flush_div_ctrl", 32'(bus.ALUCtrl), 32'd4);
    chk("flush_inready", 32'(bus.InReady), 32'd0);
    @(posedge Clock); #1;
    bus.Flush = 1'b0;
    drive(1'b0, 2'b00, 6'd0, 6'd0);
    @(negedge Clock);
    chk("post_flush_busy", 32'(bus.Busy), 32'd0);
    chk("post_flush_ctrl", 32'(bus.ALUCtrl), 32'hF);
    chk("post_flush_outvalid", 32'(bus.OutValid), 32'd0);
    chk("post_flush_inready", 32'(bus.InReady), 32'd1);
    repeat (DIV_N) @(posedge Clock);

    // Reset asserted in the middle of a MUL.
    #1;
    drive(1'b1, 2'b10, 6'd24, 6'd0);
    @(posedge Clock); #1;
    drive(1'b0, 2'b00, 6'd0, 6'd0);
    repeat (3) @(posedge Clock);
    #1 Reset = 1'b1;
    @(negedge Clock);
    chk("midrst_ctrl", 32'(bus.ALUCtrl), 32'hF);
    chk("midrst_busy", 32'(bus.Busy), 32'd0);
    chk("midrst_outvalid", 32'(bus.OutValid), 32'd0);
    @(posedge Clock); #1 Reset = 1'b0;
    @(negedge Clock);
    chk("midrst_inready", 32'(bus.InReady), 32'd1);
    @(posedge Clock); #1;
    drive(1'b1, 2'b11, 6'd0, 6'd7);
    push(4'd7, 1'b0);
    @(posedge Clock); #1;
    drive(1'b0, 2'b00, 6'd0, 6'd0);
    repeat (MUL_N) @(posedge Clock);

    chk("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_seq.md
# alu_ctrl_seq

Registered, parametrised ALU control unit for the 16-bit CPU. It decodes ALUOp, Funct and opcode into the ALU control word, and it sequences multi-cycle operations (MUL, DIV) with a valid/ready handshake and a busy counter. Single-cycle operations still sustain one operation per clock. It sits between the control unit and the ALU/datapath, and it replaces the combinational ALU control.

## Interface
- CTRL_W, 4, ALU control word width (≥4)
- FUNCT_W, 6, R-format function field width
- OP_W, 6, opcode width
- MUL_CYCLES, 8, MUL execution cycles (≥2)
- DIV_CYCLES, 16, DIV execution cycles (≥2, ≥MUL_CYCLES)

Ports:
- Clock  in  1  single clock, rising edge
- Reset  in  1  asynchronous, active-high
- InValid  in  1  decode request present
- InReady  out  1  request accepted on this edge if InValid
- ALUOp  in  2  00 lw/sw, 01 beq/bne, 10 R-format, 11 I-format
- Funct  in  FUNCT_W  R-format function code
- Opcode  in  OP_W  instruction opcode
- Flush  in  1  synchronous abort of the current operation
- ALUCtrl  out  CTRL_W  registered control word
- OutValid  out  1  one-cycle pulse: operation complete, ALU result valid
- Busy  out  1  multi-cycle operation in progress
- IllegalOp  out  1  one-cycle pulse: undecodable Funct/Opcode

## Operation
- Decode, applied on accept (InValid & InReady):
  - ALUOp 00: ADD (2).
  - ALUOp 01: SUB (6).
  - ALUOp 10, by Funct: 32 ADD→2, 34 SUB→6, 36 AND→0, 37 OR→1, 42 SLT→7, 24 MUL→3 (multi, MUL_CYCLES), 26 DIV→4 (multi, DIV_CYCLES).
  - ALUOp 11, by Opcode: 4 ADDI→2, 6 ANDI→0, 5 ORI→1, 7 SLTI→7.
- Unlisted code: ALUCtrl←NOP (all ones); IllegalOp pulses; OutValid still pulses (single-cycle path).
- States:
  - IDLE: InReady=1, Busy=0.
  - MULTI: InReady=0, Busy=1. Down-counter, width $clog2(DIV_CYCLES).
- IDLE + accept of a single-cycle op: stay IDLE. ALUCtrl updates; OutValid=1 the next cycle.
- IDLE + accept of a multi-cycle op: go MULTI. Counter←N-2 (N = MUL_CYCLES or DIV_CYCLES); ALUCtrl updates.
- MULTI, counter>0: decrement.
- MULTI, counter==0: OutValid=1 next cycle; return to IDLE.
- ALUCtrl holds its value until the next accept. It is never changed during MULTI.
- Flush has priority over everything:
  - Next state IDLE; counter cleared.
  - OutValid and IllegalOp suppressed for the flushed operation.
  - ALUCtrl←NOP.
  - InReady=0 in a Flush cycle, so a simultaneous InValid is not accepted.
- Reset (any time, including mid-MULTI): state IDLE, counter 0, ALUCtrl=NOP, OutValid=0, Busy=0, IllegalOp=0. InReady=1 once Reset deasserts.

## Timing
- Single-cycle op accepted at edge k:
  - ALUCtrl valid and OutValid high in cycle k→k+1.
  - Back-to-back accepts give OutValid continuously high.
- Multi-cycle op accepted at edge k:
  - Busy and InReady=0 for cycles k+1 … k+N-1.
  - OutValid in the cycle after edge k+N-1.
  - InReady=1 again in that same cycle, so a new accept at the next edge yields zero bubble.
- Outputs are registered except InReady, which is combinational: (state==IDLE) & ~Flush.
- Busy and OutValid are never high in the same cycle.

## Structure
- Package alu_ctrl_pkg holds:
  - ALUOp encodings.
  - Funct/opcode constants.
  - Control-word constants (ADD, SUB, AND, OR, SLT, MUL, DIV, NOP).
  - State enum.
- Sub-module alu_ctrl_decode is purely combinational. It maps ALUOp/Funct/Opcode to {ctrl, is_multi, is_div, illegal}.
- The top level holds the FSM, counter and output registers.

## Test plan
- Reset asserted mid-stream → ALUCtrl=4'hF, OutValid=0, Busy=0, InReady=1 after release.
- Back-to-back R-format ADD, SUB, AND, OR, SLT (Funct 32, 34, 36, 37, 42) → ALUCtrl 2, 6, 0, 1, 7 on consecutive cycles; OutValid high 5 cycles.
- MUL (ALUOp 10, Funct 24) with default parameters:
  - Busy high exactly 7 cycles; OutValid one cycle later; ALUCtrl=3 throughout.
  - InValid held high during Busy is not accepted until the OutValid cycle.
- DIV (Funct 26) with Flush asserted in the 5th Busy cycle, InValid also high → next cycle IDLE, ALUCtrl=NOP, no OutValid, the concurrent request not accepted.
- I-format ADDI/ANDI/ORI/SLTI (opcodes 4, 6, 5, 7) → 2, 0, 1, 7. Opcode 9 with ALUOp 11 → ALUCtrl=NOP, IllegalOp and OutValid pulse together.
- ALUOp 00 and 01 with random Funct/Opcode → ALUCtrl 2 and 6 regardless of Funct/Opcode.
